// File: rtl/blink_pkg.sv
// blink_pkg: types and helpers shared by the blink LED controller.
//   mode_t    : LED operating mode, advanced once per debounced button press.
//   next_mode : the mode that follows a given mode in the press cycle.
package blink_pkg;

    typedef enum logic [1:0] {
        MODE_SLOW = 2'd0,
        MODE_FAST = 2'd1,
        MODE_ON   = 2'd2,
        MODE_OFF  = 2'd3
    } mode_t;

    function automatic mode_t next_mode(input mode_t cur);
        mode_t nxt;
        case (cur)
            MODE_SLOW: nxt = MODE_FAST;
            MODE_FAST: nxt = MODE_ON;
            MODE_ON:   nxt = MODE_OFF;
            default:   nxt = MODE_SLOW;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/blink_btn_debounce.sv
// btn_debounce: two-flop synchronizer, counting debouncer and press pulse.
//   clk      in  : system clock
//   rst_n    in  : synchronous active-low reset
//   btn_raw  in  : raw asynchronous button, 1 = pressed
//   level    out : debounced button level
//   press    out : one-cycle pulse on each 0->1 change of the debounced level
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_q;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= btn_raw;
            r_sync2   <= r_sync1;
            r_level_q <= r_level;
            // The counter tracks how long the synchronized input has disagreed
            // with the accepted level; any agreement restarts the wait.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign level = r_level;
    assign press = r_level & ~r_level_q;

endmodule

// File: rtl/blink.sv
// blink: single-channel LED blinker with a push-button mode selector.
//   clk     in  : system clock
//   rst_n   in  : synchronous active-low reset
//   btn_0   in  : raw asynchronous push button, 1 = pressed
//   led0_b  out : registered LED drive, 1 = lit
//
// state     | meaning
// ----------+-----------------------------------------------
// MODE_SLOW | blink, half-period HALF_PERIOD_CYCLES
// MODE_FAST | blink, half-period HALF_PERIOD_CYCLES/FAST_DIV
// MODE_ON   | LED steadily lit, prescaler parked at 0
// MODE_OFF  | LED dark, prescaler parked at 0
module blink
    import blink_pkg::*;
#(
    parameter int HALF_PERIOD_CYCLES = 50_000_000,
    parameter int FAST_DIV           = 4,
    parameter int DEBOUNCE_CYCLES    = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_0,
    output logic led0_b
);

    localparam int PW = $clog2(HALF_PERIOD_CYCLES);
    localparam logic [PW-1:0] TC_SLOW = PW'(HALF_PERIOD_CYCLES - 1);
    localparam logic [PW-1:0] TC_FAST = PW'(HALF_PERIOD_CYCLES / FAST_DIV - 1);

    logic          w_btn_level;
    logic          w_btn_press;
    logic          w_advance;
    logic [PW-1:0] w_tc;

    mode_t         r_mode;
    logic [PW-1:0] r_presc;
    logic          r_phase;
    logic          r_led;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_0),
        .level   (w_btn_level),
        .press   (w_btn_press)
    );

    // A press pulse always coincides with a high debounced level; qualifying
    // on both keeps the advance tied to the accepted button state.
    assign w_advance = w_btn_press & w_btn_level;
    assign w_tc      = (r_mode == MODE_FAST) ? TC_FAST : TC_SLOW;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode  <= MODE_SLOW;
            r_presc <= '0;
            r_phase <= 1'b0;
            r_led   <= 1'b0;
        end else begin
            case (r_mode)
                MODE_SLOW, MODE_FAST: r_led <= r_phase;
                MODE_ON:              r_led <= 1'b1;
                default:              r_led <= 1'b0;
            endcase

            // A mode change takes priority over a coincident terminal count,
            // so the new mode always starts from a clean half-period.
            if (w_advance) begin
                r_mode  <= next_mode(r_mode);
                r_presc <= '0;
                r_phase <= 1'b0;
            end else if (r_mode == MODE_SLOW || r_mode == MODE_FAST) begin
                if (r_presc == w_tc) begin
                    r_presc <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_presc <= r_presc + PW'(1);
                end
            end else begin
                r_presc <= '0;
            end
        end
    end

    assign led0_b = r_led;

endmodule

// File: tb/tb_blink.sv
module tb_blink;

   localparam int HP  = 8;
   localparam int FD  = 4;
   localparam int DB  = 4;
   localparam int LAT = 2 + DB + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn_0 = 1'b0;
   logic led0_b;

   blink #(
      .HALF_PERIOD_CYCLES (HP),
      .FAST_DIV           (FD),
      .DEBOUNCE_CYCLES    (DB)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_0  (btn_0),
      .led0_b (led0_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      int   edge_n;
      logic led;
   } exp_t;

   exp_t exp_q[$];
   int   pend_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_edge  = 0;

   int   m_mode  = 0;
   int   m_start = 0;

   function automatic logic phase_of(input int md, input int start, input int e);
      if (md == 0) return logic'(((e - start) / HP) % 2);
      if (md == 1) return logic'(((e - start) / (HP / FD)) % 2);
      return 1'b0;
   endfunction

   function automatic logic led_of(input int md, input logic ph);
      if (md == 0 || md == 1) return ph;
      if (md == 2) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(input logic got, input logic exp, input string tag);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s (edge %0d mode %0d): got %b expected %b",
                  tag, n_edge, m_mode, got, exp);
      end
   endtask

   task automatic tick();
      logic rst_now;
      exp_t x;
      rst_now = ~rst_n;
      @(posedge clk);
      n_edge++;
      x.edge_n = n_edge;
      if (rst_now) begin
         x.led   = 1'b0;
         m_mode  = 0;
         m_start = n_edge;
         pend_q.delete();
      end else begin
         x.led = led_of(m_mode, phase_of(m_mode, m_start, n_edge - 1));
         if (pend_q.size() > 0 && pend_q[0] == n_edge) begin
            void'(pend_q.pop_front());
            m_mode  = (m_mode + 1) % 4;
            m_start = n_edge;
         end
      end
      exp_q.push_back(x);
      #1;
   endtask

   task automatic ticks(input int k);
      for (int i = 0; i < k; i++) tick();
   endtask

   task automatic press(input int hold);
      btn_0 = 1'b1;
      pend_q.push_back(n_edge + LAT);
      ticks(hold);
      btn_0 = 1'b0;
      ticks(12);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t x;
         x = exp_q.pop_front();
         chk(led0_b, x.led, "led0_b");
      end
   end

   initial begin
      ticks(3);
      chk(led0_b, 1'b0, "led0_b during reset");
      rst_n = 1'b1;
      ticks(40);

      press(20);
      ticks(16);

      press(6);
      ticks(16);
      press(6);
      ticks(16);
      press(6);
      ticks(20);

      btn_0 = 1'b1;
      ticks(3);
      btn_0 = 1'b0;
      ticks(12);
      for (int i = 0; i < 6; i++) begin
         btn_0 = 1'b1;
         tick();
         btn_0 = 1'b0;
         tick();
      end
      ticks(12);

      while ((n_edge + LAT - m_start) < HP || ((n_edge + LAT - m_start) % HP) != 0)
         tick();
      press(6);
      ticks(10);

      press(DB);
      ticks(10);
      press(6);
      press(6);
      ticks(10);

      btn_0 = 1'b1;
      pend_q.push_back(n_edge + LAT);
      ticks(14);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      pend_q.push_back(n_edge + LAT);
      ticks(16);
      btn_0 = 1'b0;
      ticks(24);

      @(negedge clk);
      #1;
      chk(logic'(pend_q.size() == 0 && exp_q.size() == 0), 1'b1, "expired waits drained");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/blink.md
Name: blink

Overview:
- LED blinker for a single on-board RGB channel (led0_b), driven by one push button (btn_0).
- A free-running prescaler toggles the LED at a slow or fast rate.
- Each debounced button press advances a 4-mode cycle: SLOW, FAST, ON, OFF.
- Top-level leaf block sitting directly on board pins; no bus interface.

Parameters:
- HALF_PERIOD_CYCLES, 50_000_000, clk cycles per LED half-period in SLOW mode (min 4).
- FAST_DIV, 4, FAST half-period = HALF_PERIOD_CYCLES / FAST_DIV (integer, power of 2, min 1).
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronized samples needed to accept a button level change (min 2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- btn_0  input  1  raw push button, asynchronous, active-high (1 = pressed).
- led0_b  output  1  LED drive, active-high, registered.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all state:
  - synchronizer flops and debounced level = 0; debounce counter = 0;
  - mode = SLOW; prescaler = 0; blink phase = 0; led0_b = 0 in the following cycle.
  - Reset mid-operation discards any pending press.
- Synchronizer: btn_0 passes through 2 flops (btn_s); btn_0 may change at any time.
- Debounce:
  - If btn_s equals the debounced level, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes btn_s on that edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Press event: 1-cycle pulse on the 0->1 transition of the debounced level. Release is ignored.
  - Latency from a clean btn_0 rise to the mode change is 2 + DEBOUNCE_CYCLES + 1 cycles.
- Mode FSM (2-bit state, one transition per press event): SLOW -> FAST -> ON -> OFF -> SLOW.
  - A mode change clears the prescaler and the blink phase in the same edge.
- Prescaler (width = clog2(HALF_PERIOD_CYCLES)):
  - Terminal count TC = HALF_PERIOD_CYCLES-1 in SLOW, HALF_PERIOD_CYCLES/FAST_DIV-1 in FAST.
  - At TC it wraps to 0 and the blink phase toggles; otherwise it increments.
  - Held at 0 in ON and OFF.
- Output register: led0_b <= phase in SLOW/FAST, 1 in ON, 0 in OFF.
  - led0_b lags phase/mode by one cycle.
  - In SLOW the first rise occurs HALF_PERIOD_CYCLES+1 cycles after reset release.
- Simultaneous press event and prescaler TC: the mode change wins; prescaler and phase clear, no toggle.
- Button held indefinitely: exactly one press event. The next press requires release to pass debounce first.

Decomposition:
- Shared package blink_pkg:
  - typedef enum logic [1:0] mode_t {MODE_SLOW, MODE_FAST, MODE_ON, MODE_OFF};
  - function next_mode(mode_t).
- One sub-module, btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst_n, btn_raw, level, press): holds the synchronizer, debounce counter and rise-edge pulse.
- blink holds the FSM, prescaler and output register.

Test Plan:
Bench parameters: HALF_PERIOD_CYCLES=8, FAST_DIV=4, DEBOUNCE_CYCLES=4; 10 ns clk.
1. Reset then idle, btn_0=0 -> led0_b=0 during reset; toggles every 8 cycles (first rise 9 cycles after release); period 16 cycles.
2. btn_0=1 held 20 cycles then 0 -> mode FAST exactly 7 cycles after the rise; led0_b toggles every 2 cycles; exactly one mode advance.
3. Two further clean presses -> ON (led0_b constant 1), then OFF (led0_b constant 0); a fourth press returns to SLOW with phase 0.
4. btn_0 glitch high for 3 cycles (and 1-cycle bounces) -> no mode change; led0_b pattern unchanged.
5. rst_n=0 for 1 cycle while in FAST with btn_0 held high -> mode SLOW, led0_b=0 next cycle. A press event fires 7 cycles after reset release (debounced level restarts at 0).
6. Press timed so its event coincides with prescaler TC -> mode advances, no toggle, prescaler=0.
